// File: rtl/mv_cand_gen_if.sv
// Handshake bundle between mv_cand_gen and its consumer: candidate triplet out, final mv back in.
interface mv_cand_gen_if #(
  parameter int unsigned XW = 4,
  parameter int unsigned YW = 4
);
  logic          frame_start;
  logic          cand_valid;
  logic          cand_ready;
  logic [13:0]   vec1;
  logic [13:0]   vec2;
  logic [13:0]   vec3;
  logic [XW-1:0] blk_x;
  logic [YW-1:0] blk_y;
  logic          mv_valid;
  logic [13:0]   mv;
  logic          mv_ready;
  logic          frame_done;

  modport master (
    input  frame_start, cand_ready, mv_valid, mv,
    output cand_valid, vec1, vec2, vec3, blk_x, blk_y, mv_ready, frame_done
  );

  modport slave (
    output frame_start, cand_ready, mv_valid, mv,
    input  cand_valid, vec1, vec2, vec3, blk_x, blk_y, mv_ready, frame_done
  );
endinterface

// File: rtl/mv_cand_gen.sv
// Raster-order candidate MV generator (left/top/top-right) backed by a one-row line buffer.
// Optional MV_TOPRIGHT_FALLBACK_EN: last column uses top-left as the top-right candidate.
module mv_cand_gen #(
  parameter int unsigned BLKS_X = 16,
  parameter int unsigned BLKS_Y = 12,
  parameter int unsigned XW     = $clog2(BLKS_X),
  parameter int unsigned YW     = $clog2(BLKS_Y)
) (
  input  logic           clk,
  input  logic           rst_n,
  mv_cand_gen_if.master  bus
);
  localparam int unsigned   VW     = 14;
  localparam logic [XW-1:0] X_LAST = XW'(BLKS_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(BLKS_Y - 1);

  typedef enum logic [1:0] {IDLE, LOAD, CAND, WAIT_MV} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   blk_x_q, blk_x_d;
  logic [YW-1:0]   blk_y_q, blk_y_d;
  logic [VW-1:0]   left_q, left_d;
  logic [VW-1:0]   vec1_q, vec1_d;
  logic [VW-1:0]   vec2_q, vec2_d;
  logic [VW-1:0]   vec3_q, vec3_d;
  logic            cand_valid_q, cand_valid_d;
  logic            mv_ready_q, mv_ready_d;
  logic            frame_done_q, frame_done_d;
  logic [VW-1:0]   linebuf_q [BLKS_X];
  logic [VW-1:0]   linebuf_d [BLKS_X];

  logic            cand_hs;
  logic            mv_hs;
  logic            last_blk;
  logic [XW-1:0]   tr_idx;
  logic            tr_en;

  assign cand_hs  = cand_valid_q & bus.cand_ready;
  assign mv_hs    = mv_ready_q & bus.mv_valid;
  assign last_blk = (blk_x_q == X_LAST) && (blk_y_q == Y_LAST);

  // Top-right neighbour: masked on row 0; last column has no x+1 neighbour.
  always_comb begin
    tr_idx = blk_x_q + XW'(1);
    tr_en  = (blk_y_q != '0);
    if (blk_x_q == X_LAST) begin
`ifdef MV_TOPRIGHT_FALLBACK_EN
      tr_idx = blk_x_q - XW'(1);
`else
      tr_idx = blk_x_q;
      tr_en  = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    blk_x_d      = blk_x_q;
    blk_y_d      = blk_y_q;
    left_d       = left_q;
    vec1_d       = vec1_q;
    vec2_d       = vec2_q;
    vec3_d       = vec3_q;
    frame_done_d = 1'b0;
    linebuf_d    = linebuf_q;

    case (state_q)
      IDLE: ;
      LOAD: begin
        vec1_d  = (blk_x_q == '0) ? '0 : left_q;
        vec2_d  = (blk_y_q == '0) ? '0 : linebuf_q[blk_x_q];
        vec3_d  = tr_en ? linebuf_q[tr_idx] : '0;
        state_d = CAND;
      end
      CAND: begin
        if (cand_hs) state_d = WAIT_MV;
      end
      WAIT_MV: begin
        if (mv_hs) begin
          linebuf_d[blk_x_q] = bus.mv;
          left_d             = bus.mv;
          if (last_blk) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = LOAD;
            if (blk_x_q == X_LAST) begin
              blk_x_d = '0;
              blk_y_d = blk_y_q + YW'(1);
            end else begin
              blk_x_d = blk_x_q + XW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // frame_start restarts from any state and drops a same-cycle mv write
    if (bus.frame_start) begin
      state_d      = LOAD;
      blk_x_d      = '0;
      blk_y_d      = '0;
      left_d       = '0;
      linebuf_d    = linebuf_q;
      frame_done_d = 1'b0;
    end

    cand_valid_d = (state_d == CAND);
    mv_ready_d   = (state_d == WAIT_MV);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      blk_x_q      <= '0;
      blk_y_q      <= '0;
      left_q       <= '0;
      vec1_q       <= '0;
      vec2_q       <= '0;
      vec3_q       <= '0;
      cand_valid_q <= 1'b0;
      mv_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      linebuf_q    <= '{default: '0};
    end else begin
      state_q      <= state_d;
      blk_x_q      <= blk_x_d;
      blk_y_q      <= blk_y_d;
      left_q       <= left_d;
      vec1_q       <= vec1_d;
      vec2_q       <= vec2_d;
      vec3_q       <= vec3_d;
      cand_valid_q <= cand_valid_d;
      mv_ready_q   <= mv_ready_d;
      frame_done_q <= frame_done_d;
      linebuf_q    <= linebuf_d;
    end
  end

  assign bus.cand_valid = cand_valid_q;
  assign bus.vec1       = vec1_q;
  assign bus.vec2       = vec2_q;
  assign bus.vec3       = vec3_q;
  assign bus.blk_x      = blk_x_q;
  assign bus.blk_y      = blk_y_q;
  assign bus.mv_ready   = mv_ready_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_mv_cand_gen.sv
// Scoreboard bench for mv_cand_gen (4x3 blocks): frame-level reference model, decoupled monitor.
module tb_mv_cand_gen;
  localparam int BX     = 4;
  localparam int BY     = 3;
  localparam int XW     = 2;
  localparam int YW     = 2;
  localparam int BUDGET = 20;

  typedef struct packed {
    logic [13:0]   v1;
    logic [13:0]   v2;
    logic [13:0]   v3;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } cand_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  mv_cand_gen_if #(.XW(XW), .YW(YW)) bif ();

  mv_cand_gen #(.BLKS_X(BX), .BLKS_Y(BY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: every final mv of the current frame, indexed by block position.
  logic [13:0] ref_mv [BY][BX];
  int          mx, my;
  cand_t       cand_q[$];
  int          done_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: no response within %0d cycles at cycle %0d", name, BUDGET, cyc);
  endtask

  function automatic cand_t expect_cand(input int x, input int y);
    cand_t c;
    c   = '0;
    c.x = XW'(x);
    c.y = YW'(y);
    if (x > 0) c.v1 = ref_mv[y][x-1];
    if (y > 0) begin
      c.v2 = ref_mv[y-1][x];
      if (x < BX - 1) c.v3 = ref_mv[y-1][x+1];
`ifdef MV_TOPRIGHT_FALLBACK_EN
      else c.v3 = ref_mv[y-1][x-1];
`endif
    end
    return c;
  endfunction

  task automatic model_restart();
    cand_q.delete();
    mx = 0;
    my = 0;
    for (int i = 0; i < BY; i++)
      for (int j = 0; j < BX; j++) ref_mv[i][j] = '0;
    cand_q.push_back(expect_cand(0, 0));
  endtask

  task automatic model_accept(input logic [13:0] v, input int hs);
    ref_mv[my][mx] = v;
    if (mx == BX - 1 && my == BY - 1) begin
      done_q.push_back(hs + 1);
    end else begin
      if (mx == BX - 1) begin
        mx = 0;
        my++;
      end else begin
        mx++;
      end
      cand_q.push_back(expect_cand(mx, my));
    end
  endtask

  // Monitor: pops expectations whenever the DUT completes a transfer.
  always @(negedge clk) begin
    cand_t act, exp_c;
    int    exp_t;
    if (mon_en) begin
      chk("excl_valid_ready", 64'(bif.cand_valid & bif.mv_ready), 64'(0));
      if (bif.cand_valid && bif.cand_ready) begin
        act = {bif.vec1, bif.vec2, bif.vec3, bif.blk_x, bif.blk_y};
        if (cand_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cand_extra: actual=%h expected=none at cycle %0d", act, cyc);
        end else begin
          exp_c = cand_q.pop_front();
          chk("cand", 64'(act), 64'(exp_c));
        end
      end
      if (bif.frame_done) begin
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL frame_done_extra: actual=1 expected=0 at cycle %0d", cyc);
        end else begin
          exp_t = done_q.pop_front();
          chk("frame_done_cycle", 64'(cyc), 64'(exp_t));
        end
      end
    end
  end

  task automatic start_frame(output int fs);
    bif.frame_start = 1'b1;
    fs = cyc;
    model_restart();
    @(posedge clk); #1;
    bif.frame_start = 1'b0;
  endtask

  // One block: take the candidates (optionally stalling), then return the final mv.
  task automatic do_block(input logic [13:0] v, input int stall, input bit abort,
                          output int c_first, output int c_hs, output int m_hs);
    int    n;
    cand_t snap;
    c_first = -1; c_hs = -1; m_hs = -1;
    bif.cand_ready = (stall == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bif.cand_valid && n < BUDGET);
    if (!bif.cand_valid) begin bound_fail("cand_valid_wait"); return; end
    c_first = cyc;
    if (stall > 0) begin
      snap = {bif.vec1, bif.vec2, bif.vec3, bif.blk_x, bif.blk_y};
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        bif.mv_valid = 1'($urandom);
        bif.mv       = 14'($urandom);
        @(negedge clk);
        chk("stall_hold", 64'({bif.vec1, bif.vec2, bif.vec3, bif.blk_x, bif.blk_y}), 64'(snap));
        chk("stall_valid", 64'(bif.cand_valid), 64'(1));
        chk("stall_mv_ready", 64'(bif.mv_ready), 64'(0));
      end
      @(posedge clk); #1;
      bif.mv_valid   = 1'b0;
      bif.cand_ready = 1'b1;
      @(negedge clk);
    end
    c_hs = cyc;
    @(posedge clk); #1;
    bif.cand_ready  = 1'b0;
    bif.mv_valid    = 1'b1;
    bif.mv          = v;
    bif.frame_start = abort;
    n = 0;
    do begin @(negedge clk); n++; end while (!bif.mv_ready && n < BUDGET);
    if (!bif.mv_ready) begin
      bound_fail("mv_ready_wait");
      bif.mv_valid = 1'b0; bif.frame_start = 1'b0;
      return;
    end
    m_hs = cyc;
    if (abort) model_restart();
    else       model_accept(v, m_hs);
    @(posedge clk); #1;
    bif.mv_valid    = 1'b0;
    bif.frame_start = 1'b0;
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_handshake", 64'({bif.cand_valid, bif.mv_ready}), 64'(0));
    end
    chk("done_pending", 64'(done_q.size()), 64'(0));
    chk("cand_pending", 64'(cand_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          fs, cf, ch, mh, prev;
    logic [13:0] v;

    rst_n = 1'b0;
    bif.frame_start = 1'($urandom);
    bif.cand_ready  = 1'($urandom);
    bif.mv_valid    = 1'($urandom);
    bif.mv          = 14'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bif.frame_start = 1'($urandom);
      bif.cand_ready  = 1'($urandom);
      bif.mv_valid    = 1'($urandom);
      bif.mv          = 14'($urandom);
      @(negedge clk);
      chk("reset_outputs", 64'({bif.cand_valid, bif.mv_ready, bif.frame_done, bif.vec1,
                                bif.vec2, bif.vec3, bif.blk_x, bif.blk_y}), 64'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bif.frame_start = 1'b0; bif.cand_ready = 1'b0; bif.mv_valid = 1'b0; bif.mv = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 64'({bif.cand_valid, bif.mv_ready, bif.frame_done}), 64'(0));
    end
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Row-0 candidates, then restart while the next block is loading.
    start_frame(fs);
    do_block(14'h01FE, 0, 1'b0, cf, ch, mh);
    chk("start_latency", 64'(cf - fs), 64'(2));
    do_block(14'h0AAA, 0, 1'b0, cf, ch, mh);

    // Directed row 0, stall at (1,1), full frame including (3,1).
    start_frame(fs);
    for (int b = 0; b < BX * BY; b++) begin
      v = (b < 4) ? 14'(b + 1) : 14'($urandom);
      do_block(v, (b == 5) ? 5 : 0, 1'b0, cf, ch, mh);
      if (b == 0) chk("start_latency2", 64'(cf - fs), 64'(2));
    end
    check_idle(4);

    // Abort with a simultaneous mv handshake at (2,1).
    start_frame(fs);
    for (int b = 0; b < 7; b++)
      do_block(14'($urandom), $urandom_range(0, 2), b == 6, cf, ch, mh);

    // The abort started a new frame; run it with both sides always ready.
    prev = mh;
    for (int b = 0; b < BX * BY; b++) begin
      do_block(14'($urandom), 0, 1'b0, cf, ch, mh);
      chk("load_latency", 64'(cf - prev), 64'(2));
      chk("mv_latency", 64'(mh - ch), 64'(1));
      prev = mh;
    end
    check_idle(4);

    // Random stalls and random vectors.
    start_frame(fs);
    for (int b = 0; b < BX * BY; b++)
      do_block(14'($urandom), $urandom_range(0, 3), 1'b0, cf, ch, mh);
    check_idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mv_cand_gen.md
# mv_cand_gen

Candidate motion-vector generator for the median-prediction stage. For each block of a frame, in raster order, it presents three neighbour vectors (left, top, top-right) on a valid/ready handshake. It then waits for the final motion vector of that block and stores it in a one-row line buffer, which supplies the candidates for later blocks. It is the producer feeding the three-vector median selector; vectors use the same packed format {y[6:0], x[6:0]}, two's complement per component.

## Interface
- `BLKS_X`, default 16: blocks per row (≥2).
- `BLKS_Y`, default 12: block rows per frame (≥1).
- `XW`, default `$clog2(BLKS_X)`: width of `blk_x`.
- `YW`, default `$clog2(BLKS_Y)`: width of `blk_y`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `frame_start`, in, 1: one-cycle pulse; (re)starts the frame at block (0,0).
- `cand_valid`, out, 1: candidate triplet valid.
- `cand_ready`, in, 1: downstream accepts the triplet.
- `vec1`, out, 14: left candidate.
- `vec2`, out, 14: top candidate.
- `vec3`, out, 14: top-right candidate.
- `blk_x`, out, XW: column of the current block.
- `blk_y`, out, YW: row of the current block.
- `mv_valid`, in, 1: final vector of the current block is valid.
- `mv`, in, 14: final vector, packed {y,x}.
- `mv_ready`, out, 1: block accepts `mv`.
- `frame_done`, out, 1: one-cycle pulse after the last block's `mv` is accepted.

## Operation
- **FSM states:** IDLE, LOAD, CAND, WAIT_MV.
- **IDLE:**
  - All handshake outputs are low.
  - `frame_start` → LOAD; clear `blk_x`/`blk_y` to 0 and the left register to 0.
- **LOAD:** register `vec1`/`vec2`/`vec3` from the left register and the line buffer, then go to CAND.
- **CAND:**
  - `cand_valid`=1.
  - On `cand_valid && cand_ready` → WAIT_MV.
  - `vec*`, `blk_x` and `blk_y` are held stable while stalled.
- **WAIT_MV:**
  - `mv_ready`=1.
  - On `mv_valid && mv_ready`: write `mv` to `linebuf[blk_x]` and to the left register.
  - If the block was (BLKS_X-1, BLKS_Y-1): pulse `frame_done` and go to IDLE.
  - Otherwise advance `blk_x` (wrapping to 0 and incrementing `blk_y` at the row end) and go to LOAD.
- **Candidate rules** for block (x,y); out-of-frame neighbours yield 14'd0:
  - `vec1` = mv(x-1, y); 0 when x=0.
  - `vec2` = mv(x, y-1) = `linebuf[x]`; 0 when y=0.
  - `vec3` = mv(x+1, y-1) = `linebuf[x+1]`; 0 when y=0 or x=BLKS_X-1 (see Configuration).
- **Line buffer:**
  - BLKS_X×14 registers; not cleared by `frame_start` (the row-0 rules mask stale data).
  - Reset clears it to 0.
  - The write at index x never corrupts `linebuf[x+1]`, which is still needed for the current row.
- **No arithmetic:** vectors pass through bit-exact with no sign manipulation.
- **`frame_start` outside IDLE:** aborts the frame from any state and goes to LOAD with counters and the left register cleared.
  - It takes priority over a simultaneous `mv` handshake; that `mv` is discarded and not written.
  - `frame_done` is not pulsed.
- **`frame_start` in CAND** while `cand_ready`=1: the transfer still completes on the handshake cycle, but the FSM goes to LOAD, not WAIT_MV.

## Timing
- Reset values: state IDLE; `cand_valid`, `mv_ready`, `frame_done` = 0; `vec1`/`vec2`/`vec3` = 0; `blk_x`/`blk_y` = 0.
- `frame_start` sampled at edge N → LOAD in cycle N+1 → `cand_valid`=1 from cycle N+2.
- `cand` handshake at edge C → `mv_ready`=1 from C+1.
- `mv` handshake at edge M → `cand_valid` for the next block from M+2 (one LOAD cycle).
- Last block's `mv` handshake at edge M → `frame_done`=1 during cycle M+1 only; IDLE from M+1.
- Steady-state throughput is one block per 3 cycles when both sides are always ready.
- `mv_ready` and `cand_valid` are never high in the same cycle.

## Configuration
- Macro `MV_TOPRIGHT_FALLBACK_EN`.
- Defined: at x=BLKS_X-1 and y>0, `vec3` = mv(x-1, y-1) (top-left, `linebuf[x-1]`) instead of 0.
- Undefined: `vec3` = 0 at the last column.
- All other behaviour and timing are identical in both builds.

## Test plan
All scenarios use BLKS_X=4, BLKS_Y=3.
- **Reset:** assert `rst_n`=0 for 2 cycles with random inputs → all outputs 0; `cand_valid` stays 0 with no `frame_start`.
- **Row 0:**
  - `frame_start`, accept; block (0,0) → `vec1`/`vec2`/`vec3` = 0, `cand_valid` 2 cycles after the pulse.
  - Feed mv = 14'h01FE (y=3, x=-2); block (1,0) → `vec1`=14'h01FE, `vec2`=`vec3`=0.
- **Row 1 candidates:**
  - Row 0 mvs = 14'h0001, 14'h0002, 14'h0003, 14'h0004.
  - Block (0,1) → `vec1`=0, `vec2`=14'h0001, `vec3`=14'h0002.
  - Block (3,1) → `vec2`=14'h0004, `vec3`=0 (macro off) or 14'h0003 (macro on).
- **Backpressure:** hold `cand_ready`=0 for 5 cycles in CAND → `vec*`/`blk_*` stable and `mv_ready`=0; `mv_valid` pulses meanwhile are ignored.
- **Abort:** `frame_start` in the same cycle as an `mv` handshake at block (2,1) → no write (`linebuf[2]` unchanged), next candidates are for (0,0) and all zero, no `frame_done`.
- **Full frame:** 12 blocks with always-ready sides → `frame_done` once, exactly 1 cycle after the 12th `mv` handshake; 3 cycles per block; then IDLE.
